// File: rtl/idx_alloc.sv
// Round-robin free-list allocator. Offers the next free entry (searching from a
// rotating pointer), accepts releases by encoded index, tracks occupancy, and
// pulses o_err one cycle after any illegal request.
module idx_alloc #(
  parameter int unsigned N = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_alloc_vld,
  output logic                      o_alloc_rdy,
  output logic [$clog2(N)-1:0]      o_alloc_idx,
  input  logic                      i_free_vld,
  input  logic [$clog2(N)-1:0]      i_free_idx,
  output logic [N-1:0]              o_busy,
  output logic [$clog2(N+1)-1:0]    o_cnt,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_err
);

  localparam int unsigned W  = $clog2(N);
  localparam int unsigned CW = $clog2(N+1);

  logic [N-1:0]  busy_q, busy_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          offer_vld;
  logic [W-1:0]  offer_idx;
  logic [W-1:0]  cand;
  logic          alloc_ok, alloc_err, free_ok, free_err;

  // Offer search: descending loop so the smallest distance from ptr wins.
  always_comb begin
    offer_vld = 1'b0;
    offer_idx = '0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_q + W'(k);
      if (!busy_q[cand]) begin
        offer_vld = 1'b1;
        offer_idx = cand;
      end
    end
  end

  // Request legality and next-state computation.
  always_comb begin
    alloc_ok  = i_alloc_vld & offer_vld;
    alloc_err = i_alloc_vld & ~offer_vld;
    // Freeing an idle entry (including the one being allocated now) is a double free.
    free_ok   = i_free_vld & busy_q[i_free_idx];
    free_err  = i_free_vld & ~busy_q[i_free_idx];

    busy_d = busy_q;
    if (free_ok)  busy_d[i_free_idx] = 1'b0;
    if (alloc_ok) busy_d[offer_idx]  = 1'b1;

    ptr_d = alloc_ok ? offer_idx + W'(1) : ptr_q;
    cnt_d = cnt_q + CW'(alloc_ok) - CW'(free_ok);
    err_d = alloc_err | free_err;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Outputs derive from registered state only.
  always_comb begin
    o_alloc_rdy = offer_vld;
    o_alloc_idx = offer_idx;
    o_busy      = busy_q;
    o_cnt       = cnt_q;
    o_full      = (cnt_q == CW'(N));
    o_empty     = (cnt_q == '0);
    o_err       = err_q;
  end

endmodule

// File: tb/tb_idx_alloc.sv
// Bench for idx_alloc: directed vectors with literal expectations, a per-cycle
// comparison against a set-based behavioural model, and a random scoreboard run.
module tb_idx_alloc;
  localparam int N  = 16;
  localparam int W  = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_alloc_vld = 1'b0;
  logic          o_alloc_rdy;
  logic [W-1:0]  o_alloc_idx;
  logic          i_free_vld = 1'b0;
  logic [W-1:0]  i_free_idx = '0;
  logic [N-1:0]  o_busy;
  logic [CW-1:0] o_cnt;
  logic          o_full, o_empty, o_err;

  int checks = 0;
  int errors = 0;

  idx_alloc #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_alloc_vld (i_alloc_vld),
    .o_alloc_rdy (o_alloc_rdy),
    .o_alloc_idx (o_alloc_idx),
    .i_free_vld  (i_free_vld),
    .i_free_idx  (i_free_idx),
    .o_busy      (o_busy),
    .o_cnt       (o_cnt),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a set of allocated entries plus a next-search start.
  bit m_busy[N];
  int m_ptr = 0;
  bit m_err = 0;
  bit m_valid = 0;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Returns -1 when nothing is free.
  function automatic int m_offer();
    for (int k = 0; k < N; k++)
      if (!m_busy[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        m_ptr   = 0;
        m_err   = 0;
        m_valid = 1;
      end else begin
        int  off;
        bit  aok, aerr, fok, ferr;
        int  fi;
        off  = m_offer();
        fi   = int'(i_free_idx);
        aok  = i_alloc_vld && off >= 0;
        aerr = i_alloc_vld && off < 0;
        fok  = i_free_vld && m_busy[fi];
        ferr = i_free_vld && !m_busy[fi];
        if (fok) m_busy[fi] = 0;
        if (aok) begin
          m_busy[off] = 1;
          m_ptr = (off + 1) % N;
        end
        m_err = aerr || ferr;
      end
    end
  end

  // Every cycle once the model is initialised, compare all outputs.
  always @(negedge clk) begin
    if (m_valid && !rst) begin
      int off;
      logic [N-1:0] eb;
      off = m_offer();
      for (int i = 0; i < N; i++) eb[i] = m_busy[i];
      check("rdy", int'(o_alloc_rdy), int'(off >= 0));
      check("idx", int'(o_alloc_idx), (off >= 0) ? off : 0);
      check("busy", int'(o_busy), int'(eb));
      check("cnt", int'(o_cnt), m_count());
      check("full", int'(o_full), int'(m_count() == N));
      check("empty", int'(o_empty), int'(m_count() == 0));
      check("err", int'(o_err), int'(m_err));
      check("popcount", $countones(o_busy), int'(o_cnt));
    end
  end

  // One clock cycle with the given request; outputs are settled on return.
  task automatic cyc(input bit a, input bit f, input int fi);
    i_alloc_vld = a;
    i_free_vld  = f;
    i_free_idx  = W'(fi);
    @(posedge clk);
    #1;
    i_alloc_vld = 1'b0;
    i_free_vld  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
  endtask

  bit owned[N];

  initial begin
    // 1: reset state, then fill in order.
    do_reset();
    check("rst_rdy", int'(o_alloc_rdy), 1);
    check("rst_idx", int'(o_alloc_idx), 0);
    check("rst_empty", int'(o_empty), 1);
    check("rst_full", int'(o_full), 0);
    check("rst_err", int'(o_err), 0);
    for (int i = 0; i < N; i++) begin
      check("fill_idx", int'(o_alloc_idx), i);
      cyc(1, 0, 0);
      check("fill_cnt", int'(o_cnt), i + 1);
    end
    check("fill_full", int'(o_full), 1);
    check("fill_rdy", int'(o_alloc_rdy), 0);

    // Alloc while full: error pulse, no state change.
    cyc(1, 0, 0);
    check("ovf_err", int'(o_err), 1);
    check("ovf_cnt", int'(o_cnt), 16);
    cyc(0, 0, 0);
    check("ovf_err_clr", int'(o_err), 0);

    // 2: free 5 then realloc; free 3 and 9, wrap-around order 9 then 3.
    cyc(0, 1, 5);
    check("f5_idx", int'(o_alloc_idx), 5);
    check("f5_cnt", int'(o_cnt), 15);
    cyc(1, 0, 0);
    check("re5_cnt", int'(o_cnt), 16);
    cyc(0, 1, 3);
    cyc(0, 1, 9);
    check("wrap_idx9", int'(o_alloc_idx), 9);
    cyc(1, 0, 0);
    check("wrap_idx3", int'(o_alloc_idx), 3);
    cyc(1, 0, 0);
    check("wrap_full", int'(o_full), 1);

    // Full with alloc + free together: alloc illegal, free succeeds.
    cyc(1, 1, 0);
    check("fullaf_err", int'(o_err), 1);
    check("fullaf_rdy", int'(o_alloc_rdy), 1);
    check("fullaf_idx", int'(o_alloc_idx), 0);
    check("fullaf_cnt", int'(o_cnt), 15);

    // 3: busy={0,1,2}, ptr=3; alloc + free 1 together.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    check("s3_idx", int'(o_alloc_idx), 3);
    cyc(1, 1, 1);
    check("s3_busy", int'(o_busy), 'h000D);
    check("s3_cnt", int'(o_cnt), 3);
    check("s3_idx4", int'(o_alloc_idx), 4);

    // 4: double free of idle entry 7.
    cyc(0, 1, 7);
    check("df_err", int'(o_err), 1);
    check("df_busy", int'(o_busy), 'h000D);
    check("df_cnt", int'(o_cnt), 3);
    cyc(0, 0, 0);
    check("df_err_clr", int'(o_err), 0);

    // Free of the index being allocated: alloc wins, error pulses.
    cyc(1, 1, 4);
    check("sf_busy", int'(o_busy), 'h001D);
    check("sf_err", int'(o_err), 1);
    check("sf_cnt", int'(o_cnt), 4);

    // 5: reset mid-stream with alloc requested.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);
    check("m5_cnt", int'(o_cnt), 10);
    rst = 1'b1;
    cyc(1, 0, 0);
    rst = 1'b0;
    check("m5_busy", int'(o_busy), 0);
    check("m5_cnt0", int'(o_cnt), 0);
    check("m5_empty", int'(o_empty), 1);
    check("m5_idx", int'(o_alloc_idx), 0);
    check("m5_err", int'(o_err), 0);

    // 6: random stream with ownership scoreboard.
    for (int i = 0; i < N; i++) owned[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      bit a, f;
      int fi, ai;
      a  = ($urandom_range(0, 99) < 55);
      fi = $urandom_range(0, N - 1);
      f  = owned[fi] ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 3);
      ai = int'(o_alloc_idx);
      if (a && o_alloc_rdy) begin
        check("sb_dup", int'(owned[ai]), 0);
        if (f && owned[fi]) check("sb_reoffer", int'(ai == fi), 0);
      end
      if (f && owned[fi]) owned[fi] = 0;
      if (a && o_alloc_rdy) owned[ai] = 1;
      cyc(a, f, fi);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
